// File: rtl/stream_demux_if.sv
// Handshake bundle for the 1-to-N stream demux: one producer-facing input
// and N consumer-facing outputs that share a single payload/select bus.
interface stream_demux_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int SW   = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sel;
    logic            in_bcast;
    logic [N_CH-1:0] out_valid;
    logic [N_CH-1:0] out_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_sel;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux holding one beat; a per-channel pending mask
// tracks which consumers still owe a handshake (unicast, broadcast or drop).
//
// state | meaning
// EMPTY | pending == 0, no beat held, in_ready = 1
// HOLD  | pending != 0, beat held until every pending channel accepts
module stream_demux_1ton #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int SW   = 2,
    parameter int CW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_demux_if.slave        bus,
    output logic                 busy,
    output logic [CW-1:0]        drop_cnt
);

    localparam logic [N_CH-1:0] ONE_LSB = {{(N_CH-1){1'b0}}, 1'b1};

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pending_nxt;
    logic [DW-1:0]   data_q;
    logic [SW-1:0]   sel_q;
    logic [CW-1:0]   drop_nxt;
    logic            done;
    logic            accept;

    // in_ready looks through out_ready so the final handshake and the next
    // load share one edge, giving a beat per cycle with ready consumers.
    assign done   = ((pending & ~bus.out_ready) == '0);
    assign accept = bus.in_valid & done;

    always_comb begin
        pending_nxt = pending & ~bus.out_ready;
        drop_nxt    = drop_cnt;
        if (accept) begin
            if (bus.in_bcast) begin
                pending_nxt = '1;
            end else if (int'(bus.in_sel) < N_CH) begin
                pending_nxt = ONE_LSB << bus.in_sel;
            end else begin
                pending_nxt = '0;
                if (drop_cnt != '1) begin
                    drop_nxt = drop_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            drop_cnt <= drop_nxt;
            if (accept) begin
                data_q <= bus.in_data;
                sel_q  <= bus.in_sel;
            end
        end
    end

    assign bus.in_ready  = done;
    assign bus.out_valid = pending;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign busy          = |pending;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for stream_demux_1ton: a 4-channel instance for routing,
// backpressure, broadcast and reset, and a 3-channel CW=2 instance for drops.
module tb_stream_demux_1ton;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    stream_demux_if #(.N_CH(4), .DW(8), .SW(2)) if4 ();
    stream_demux_if #(.N_CH(3), .DW(8), .SW(2)) if3 ();

    logic       busy4, busy3;
    logic [7:0] drop4;
    logic [1:0] drop3;

    stream_demux_1ton #(.N_CH(4), .DW(8), .SW(2), .CW(8)) dut4 (
        .clk(clk), .rst(rst), .bus(if4.slave), .busy(busy4), .drop_cnt(drop4)
    );

    stream_demux_1ton #(.N_CH(3), .DW(8), .SW(2), .CW(2)) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave), .busy(busy3), .drop_cnt(drop3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_data [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [3:0] sweep_vld  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] bc_vld     [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [1:0] drop_exp   [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_sel = '0; if4.in_bcast = 1'b0;
        if4.out_ready = '0;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.in_sel = '0; if3.in_bcast = 1'b0;
        if3.out_ready = '0;

        #3;
        chk("rst_out_valid", 32'(if4.out_valid), 32'h0);
        chk("rst_busy",      32'(busy4), 32'h0);
        chk("rst_in_ready",  32'(if4.in_ready), 32'h1);
        chk("rst_out_data",  32'(if4.out_data), 32'h0);
        chk("rst_drop",      32'(drop4), 32'h0);
        #4 rst = 1'b0;
        tick();

        // unicast sweep, one beat per cycle
        if4.out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1'b1;
            if4.in_data  = sweep_data[i];
            if4.in_sel   = 2'(i);
            #1 chk("sweep_in_ready", 32'(if4.in_ready), 32'h1);
            tick();
            chk("sweep_out_valid", 32'(if4.out_valid), 32'(sweep_vld[i]));
            chk("sweep_out_data",  32'(if4.out_data), 32'(sweep_data[i]));
        end
        if4.in_valid = 1'b0;
        tick();
        chk("sweep_drain_valid", 32'(if4.out_valid), 32'h0);
        chk("sweep_drain_busy",  32'(busy4), 32'h0);

        // backpressure on ch2, then handoff to a queued beat on the same edge
        if4.out_ready = 4'b0000;
        if4.in_valid  = 1'b1; if4.in_data = 8'h5A; if4.in_sel = 2'd2;
        tick();
        if4.in_data = 8'h66; if4.in_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_out_valid", 32'(if4.out_valid), 32'h4);
            chk("bp_in_ready",  32'(if4.in_ready), 32'h0);
            chk("bp_out_data",  32'(if4.out_data), 32'h5A);
            tick();
        end
        if4.out_ready = 4'b0100;
        #1 chk("bp_release_ready", 32'(if4.in_ready), 32'h1);
        tick();
        if4.in_valid = 1'b0; if4.out_ready = 4'b0000;
        chk("bp_next_valid", 32'(if4.out_valid), 32'h2);
        chk("bp_next_data",  32'(if4.out_data), 32'h66);
        chk("bp_next_sel",   32'(if4.out_sel), 32'h1);

        // ready on non-pending channels has no effect
        if4.out_ready = 4'b1101;
        #1 chk("nt_in_ready", 32'(if4.in_ready), 32'h0);
        tick();
        chk("nt_out_valid", 32'(if4.out_valid), 32'h2);
        if4.out_ready = 4'b0010;
        tick();
        if4.out_ready = 4'b0000;
        chk("nt_drain", 32'(if4.out_valid), 32'h0);

        // broadcast drained one channel per cycle
        if4.in_valid = 1'b1; if4.in_data = 8'h3C; if4.in_bcast = 1'b1; if4.in_sel = 2'd0;
        tick();
        if4.in_valid = 1'b0; if4.in_bcast = 1'b0;
        chk("bc_all_valid", 32'(if4.out_valid), 32'hF);
        for (int k = 0; k < 4; k++) begin
            if4.out_ready = 4'(1 << k);
            #1 chk("bc_in_ready", 32'(if4.in_ready), (k == 3) ? 32'h1 : 32'h0);
            tick();
            chk("bc_out_valid", 32'(if4.out_valid), 32'(bc_vld[k]));
            chk("bc_out_data",  32'(if4.out_data), 32'h3C);
        end
        if4.out_ready = 4'b0000;

        // out-of-range selects on the 3-channel instance, saturating at 3
        if3.out_ready = 3'b111;
        if3.in_valid = 1'b1; if3.in_data = 8'h11; if3.in_sel = 2'd3;
        #1 chk("oor_in_ready", 32'(if3.in_ready), 32'h1);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("oor_out_valid", 32'(if3.out_valid), 32'h0);
            chk("oor_drop_cnt",  32'(drop3), 32'(drop_exp[n]));
        end
        if3.in_sel = 2'd2; if3.in_data = 8'h22; if3.out_ready = 3'b000;
        tick();
        if3.in_valid = 1'b0;
        chk("n3_inrange_valid", 32'(if3.out_valid), 32'h4);
        chk("n3_drop_hold",     32'(drop3), 32'h3);

        // reset while a broadcast is partially delivered
        if4.in_valid = 1'b1; if4.in_data = 8'h77; if4.in_bcast = 1'b1; if4.in_sel = 2'd3;
        tick();
        if4.in_valid = 1'b0; if4.in_bcast = 1'b0;
        if4.out_ready = 4'b0101;
        tick();
        if4.out_ready = 4'b0000;
        chk("mid_out_valid", 32'(if4.out_valid), 32'hA);
        #2 rst = 1'b1;
        #1;
        chk("mr_out_valid", 32'(if4.out_valid), 32'h0);
        chk("mr_out_data",  32'(if4.out_data), 32'h0);
        chk("mr_out_sel",   32'(if4.out_sel), 32'h0);
        chk("mr_busy",      32'(busy4), 32'h0);
        chk("mr_in_ready",  32'(if4.in_ready), 32'h1);
        chk("mr_n3_valid",  32'(if3.out_valid), 32'h0);
        chk("mr_n3_drop",   32'(drop3), 32'h0);
        #3 rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
